// File: rtl/aes_sub_bytes_iter.sv
// aes_sub_bytes_iter: iterative forward AES SubBytes engine.
//
// Accepts one 128-bit state on the input handshake. It substitutes
// BYTES_PER_CYCLE bytes per clock through the forward S-box, then presents
// the result on the output handshake. The output and input handshakes never
// overlap.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_data valid
//   in_ready   engine can accept a state (IDLE)
//   in_data    input state; byte i = in_data[127-8i -: 8]
//   out_valid  out_data holds the finished state (DONE)
//   out_ready  consumer accepts out_data
//   out_data   working register; final only while out_valid=1
//   busy       high in SUB or DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a state, in_ready=1
// SUB   | substituting BYTES_PER_CYCLE bytes per clock
// DONE  | result presented, waiting for out_ready

module aes_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int WIN_W     = 8 * BYTES_PER_CYCLE;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("aes_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Forward S-box. Entry n sits at SBOX_TABLE[2047-8n -: 8], row-major from 0x00.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t              fsm;
  logic [STEP_W-1:0]   step;
  logic [127:0]        state_q;
  logic [127:0]        state_next;
  logic [WIN_W-1:0]    win;
  logic [WIN_W-1:0]    sub_win;
  int                  win_base;

  // Window of bytes handled this step: bytes step*BPC .. step*BPC+BPC-1,
  // counted from the MSB end of the register.
  always_comb begin
    win_base   = 127 - int'(step) * WIN_W;
    win        = state_q[win_base -: WIN_W];
    sub_win    = '0;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      sub_win[WIN_W-1-8*k -: 8] = sbox(win[WIN_W-1-8*k -: 8]);
    end
    state_next = state_q;
    state_next[win_base -: WIN_W] = sub_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      step      <= '0;
      state_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_data;
            step     <= '0;
            fsm      <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          state_q <= state_next;
          if (step == LAST_STEP) begin
            step      <= '0;
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          step      <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Driven straight from the working register; partial results show during SUB.
  assign out_data = state_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// tb_aes_sub_bytes_iter: self-checking bench for aes_sub_bytes_iter.
// Instance g uses BYTES_PER_CYCLE = 1<<g (1, 2, 4, 8, 16). Expected states
// come from an S-box derived arithmetically (GF(2^8) inverse + affine map)
// or from published constants, and are queued as each block is driven.

module tb_aes_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [5];
  logic [127:0] in_data   [5];
  logic         out_ready [5];
  logic         in_ready  [5];
  logic         out_valid [5];
  logic [127:0] out_data  [5];
  logic         busy      [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  int           checks = 0;
  int           errors = 0;
  logic [127:0] sb_q[$];
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] v);
    logic [7:0] r = 8'h01;
    logic [7:0] base = v;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[d[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[d[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // accepting edge.
  task automatic start_block(input int idx, input logic [127:0] d,
                             input logic [127:0] exp, input bit push);
    check($sformatf("in_ready_idle_bpc%0d", 1 << idx), 128'(in_ready[idx]), 128'(1));
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    if (push) sb_q.push_back(exp);
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_out(input int idx, input int exp_lat, output logic [127:0] got);
    int lat = 0;
    logic [127:0] exp;
    while (out_valid[idx] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_bpc%0d", 1 << idx), 128'(lat), 128'(exp_lat));
    got = out_data[idx];
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 128'(sb_q.size()), 128'(1));
    end else begin
      exp = sb_q.pop_front();
      check($sformatf("out_data_bpc%0d", 1 << idx), got, exp);
    end
  endtask

  task automatic expect_consumed(input int idx);
    @(negedge clk);
    check($sformatf("out_valid_drop_bpc%0d", 1 << idx), 128'(out_valid[idx]), 128'(0));
    check($sformatf("in_ready_back_bpc%0d", 1 << idx), 128'(in_ready[idx]), 128'(1));
  endtask

  logic [127:0] vec_in  [4];
  logic [127:0] vec_out [4];

  initial begin
    logic [127:0] got;
    logic [127:0] a;
    logic [127:0] b;
    int spurious;

    for (int i = 0; i < 256; i++) sb[i] = model_sbox(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    vec_in[0]  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vec_out[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
    vec_in[1]  = 128'h00000000000000000000000000000000;
    vec_out[1] = 128'h63636363636363636363636363636363;
    vec_in[2]  = 128'hffffffffffffffffffffffffffffffff;
    vec_out[2] = 128'h16161616161616161616161616161616;
    vec_in[3]  = 128'h000102030405060708090a0b0c0d0e0f;
    vec_out[3] = 128'h637c777bf26b6fc53001672bfed7ab76;

    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_in_ready_bpc%0d", 1 << i), 128'(in_ready[i]), 128'(1));
      check($sformatf("rst_out_valid_bpc%0d", 1 << i), 128'(out_valid[i]), 128'(0));
      check($sformatf("rst_busy_bpc%0d", 1 << i), 128'(busy[i]), 128'(0));
      check($sformatf("rst_out_data_bpc%0d", 1 << i), out_data[i], 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Published vectors at BPC=4.
    for (int v = 0; v < 4; v++) begin
      start_block(2, vec_in[v], vec_out[v], 1'b1);
      check("busy_in_sub", 128'(busy[2]), 128'(1));
      wait_out(2, 4, got);
      expect_consumed(2);
    end

    // Backpressure: DONE holds for 10 cycles with a second request pending.
    a = rand_state();
    b = rand_state();
    out_ready[2] = 1'b0;
    start_block(2, a, sub_state(a), 1'b1);
    wait_out(2, 4, got);
    in_valid[2] = 1'b1;
    in_data[2]  = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid[2]), 128'(1));
      check("bp_out_data", out_data[2], sub_state(a));
      check("bp_in_ready", 128'(in_ready[2]), 128'(0));
    end
    out_ready[2] = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 128'(out_valid[2]), 128'(0));
    check("bp_release_in_ready", 128'(in_ready[2]), 128'(1));
    sb_q.push_back(sub_state(b));
    @(negedge clk);
    in_valid[2] = 1'b0;
    check("bp_second_accepted", 128'(in_ready[2]), 128'(0));
    wait_out(2, 4, got);
    expect_consumed(2);

    // Reset after two SUB edges drops the block without output.
    a = rand_state();
    start_block(2, a, sub_state(a), 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 128'(in_ready[2]), 128'(1));
    check("midrst_out_valid", 128'(out_valid[2]), 128'(0));
    check("midrst_out_data", out_data[2], 128'(0));
    check("midrst_busy", 128'(busy[2]), 128'(0));
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[2] !== 1'b0) spurious++;
    end
    check("midrst_no_output", 128'(spurious), 128'(0));

    // Random round trip through the inverse S-box for every width.
    for (int idx = 0; idx < 5; idx++) begin
      for (int n = 0; n < 1000; n++) begin
        a = rand_state();
        start_block(idx, a, sub_state(a), 1'b1);
        wait_out(idx, 16 >> idx, got);
        check($sformatf("roundtrip_bpc%0d", 1 << idx), inv_state(got), a);
        expect_consumed(idx);
      end
    end

    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
- Iterative forward SubBytes engine for the AES encryption datapath; the encrypt-side counterpart of the existing inverse S-box lookup used in decryption.
- Accepts one 128-bit AES state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through instances of the FIPS-197 forward S-box (FIPS-197 Fig. 7).
- Returns the substituted state over a second valid/ready handshake. Sits between AddRoundKey and ShiftRows in the encrypt round controller.

Parameters:
- BYTES_PER_CYCLE, 4, number of forward S-box lookups per clock. Legal values: 1, 2, 4, 8, 16; any other value is an elaboration error.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived (localparam), number of SUB cycles per block.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  AES state. Byte i = in_data[127-8i -: 8]; byte 0 is the MSB byte (FIPS-197 input order).
- out_valid  output  1  out_data holds the finished substituted state.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  substituted state, same byte ordering as in_data.
- busy  output  1  high in SUB or DONE.

Behaviour:
- Reset: the synchronous reset is sampled on the clock edge; it is synchronous and active-high. It forces state=IDLE, step counter=0, the state register to 0, in_ready=1, out_valid=0, busy=0, out_data=0. Reset mid-operation discards the in-flight block with no output.
- FSM states: IDLE, SUB, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, in_data is captured into the internal 128-bit register, counter=0, and the FSM moves to SUB. With in_valid=0 it stays in IDLE.
- SUB: in_ready=0. Each edge replaces bytes [counter*BPC .. counter*BPC+BPC-1] of the register with S(byte) and increments the counter. On the edge where counter==NUM_STEPS-1, the FSM moves to DONE and the counter returns to 0.
- DONE: out_valid=1 and out_data = register, held stable until handshake. On an edge with out_ready=1 the FSM moves to IDLE and out_valid drops. In DONE, in_ready=0; no overlap of output and input handshakes.
- Latency: out_valid rises NUM_STEPS cycles after the input-handshake edge (4 cycles at BPC=4, 16 at BPC=1, 1 at BPC=16).
- Throughput: one block per NUM_STEPS+2 cycles when out_ready is held high.
- in_valid asserted in SUB/DONE is ignored; upstream must hold it until in_ready.
- out_data is only meaningful while out_valid=1. It is driven straight from the register, so intermediate partially substituted values are visible during SUB.
- S-box lookups are purely combinational from register bytes. No arithmetic; the counter width is clog2(NUM_STEPS) with a 1-bit minimum, and wrap-around is never reached because the FSM exits at NUM_STEPS-1.

Test Plan:
- FIPS-197 App. B round 1, BPC=4: in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_valid exactly 4 cycles after acceptance.
- Corner bytes: in_data all 00 -> all 63; all FF -> all 16; 0x00010203...0F pattern -> 637c777bf26b6fc53001672bfed7ab76.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/out_data stable, in_ready=0, second in_valid ignored. Release -> IDLE next edge and the second block is accepted.
- Reset mid-SUB (assert rst after 2 SUB edges) -> next cycle in_ready=1, out_valid=0, out_data=0, busy=0; no spurious output.
- Round trip: 1000 random states passed through this block, then through the existing inverse S-box per byte -> identity. Repeat for BPC=1, 2, 8, 16 and check latency = NUM_STEPS.
